countdown_controller: RTL and testbench

Sequencing controller for the parameterized N-bit down-counter datapath on the lab board. It conditions the load and subtract pushbuttons (synchronize, debounce, edge-detect) and loads the initial value from the switches. It schedules decrements either manually, one per press, or automatically at a fixed tick rate, and stops at zero instead of wrapping. Its `count` output feeds the existing binary-to-BCD and dual seven-segment display path unchanged.

---
 rtl/countdown_pkg.sv | 16 +
 rtl/countdown_controller_btn_conditioner.sv | 49 ++++
 rtl/countdown_controller.sv | 121 ++++++++++++
 tb/tb_countdown_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown controller: FSM state encoding as seen on state_out.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_READY = 2'd1;
    localparam logic [1:0] ENC_RUN   = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

endpackage

// File: rtl/countdown_controller_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, down-counting debouncer, rising-edge press pulse.
// A clean raw edge sampled on clock edge 1 gives press high after edge 2 + DEBOUNCE_CYCLES.
module btn_conditioner
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, press_q;
    logic [CW-1:0] db_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            db_cnt_q <= DB_LAST;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                db_cnt_q <= DB_LAST;
            end else if (db_cnt_q == '0) begin
                // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the new level
                level_q  <= sync2_q;
                press_q  <= sync2_q;
                db_cnt_q <= DB_LAST;
            end else begin
                db_cnt_q <= db_cnt_q - CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/countdown_controller.sv
// Countdown sequencer: loads from switches, steps manually or on a fixed tick, saturates at zero.
//   state | meaning
//   IDLE  | after reset, count = 0, waits for a load
//   READY | loaded, count > 0, manual steps or waiting for auto_en
//   RUN   | automatic countdown, one decrement per TICK_CYCLES
//   DONE  | count reached 0, only a load leaves
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int N               = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_CYCLES     = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         btn_load,
    input  logic         btn_sub,
    input  logic         auto_en,
    output logic [N-1:0] count,
    output logic         zero,
    output logic [1:0]   state_out,
    output logic         dec_strobe
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic          load_p, sub_p;
    logic          auto1_q, auto_s_q;
    state_t        state_q;
    logic [N-1:0]  count_q;
    logic [TW-1:0] tick_q;
    logic          zero_q, strobe_q;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_cond (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_load),
        .level   (),
        .press   (load_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub_cond (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_sub),
        .level   (),
        .press   (sub_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto1_q  <= 1'b0;
            auto_s_q <= 1'b0;
        end else begin
            auto1_q  <= auto_en;
            auto_s_q <= auto1_q;
        end
    end

    // The tick timer is a down-counter; terminal count 0 marks TICK_CYCLES elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tick_q   <= TICK_LAST;
            zero_q   <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (load_p) begin
                count_q <= data_in;
                tick_q  <= TICK_LAST;
                zero_q  <= (data_in == '0);
                state_q <= (data_in == '0) ? DONE : READY;
            end else begin
                case (state_q)
                    READY: begin
                        if (auto_s_q) begin
                            state_q <= RUN;
                            tick_q  <= TICK_LAST;
                        end else if (sub_p && count_q != '0) begin
                            count_q  <= count_q - N'(1);
                            strobe_q <= 1'b1;
                            if (count_q == N'(1)) begin
                                zero_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                    RUN: begin
                        if (!auto_s_q) begin
                            state_q <= READY;
                            tick_q  <= TICK_LAST;
                        end else if (tick_q == '0) begin
                            tick_q <= TICK_LAST;
                            if (count_q != '0) begin
                                count_q  <= count_q - N'(1);
                                strobe_q <= 1'b1;
                                if (count_q == N'(1)) begin
                                    zero_q  <= 1'b1;
                                    state_q <= DONE;
                                end
                            end
                        end else begin
                            tick_q <= tick_q - TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign count      = count_q;
    assign zero       = zero_q;
    assign state_out  = state_q;
    assign dec_strobe = strobe_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Directed self-checking bench for countdown_controller with short debounce and tick periods.
module tb_countdown_controller;

    localparam int N  = 6;
    localparam int DB = 4;
    localparam int TK = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] data_in = '0;
    logic         btn_load = 1'b0;
    logic         btn_sub = 1'b0;
    logic         auto_en = 1'b0;
    logic [N-1:0] count;
    logic         zero;
    logic [1:0]   state_out;
    logic         dec_strobe;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int s0;

    countdown_controller #(.N(N), .DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TK)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .btn_load   (btn_load),
        .btn_sub    (btn_sub),
        .auto_en    (auto_en),
        .count      (count),
        .zero       (zero),
        .state_out  (state_out),
        .dec_strobe (dec_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dec_strobe) strobe_cnt <= strobe_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) check("zero_vs_count", int'(zero), int'(count == '0));

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_load(input logic [N-1:0] v);
        data_in  = v;
        btn_load = 1'b1;
        cyc(DB + 8);
        btn_load = 1'b0;
        cyc(DB + 8);
    endtask

    task automatic press_sub();
        btn_sub = 1'b1;
        cyc(DB + 8);
        btn_sub = 1'b0;
        cyc(DB + 8);
    endtask

    initial begin
        cyc(3);
        check("rst_count", count, 0);
        check("rst_zero", zero, 1);
        check("rst_state", state_out, 0);
        check("rst_strobe", dec_strobe, 0);
        rst = 1'b1;
        cyc(3);
        check("idle_hold", state_out, 0);

        // Manual stepping 3 -> 0
        press_load(6'd3);
        check("man_load_cnt", count, 3);
        check("man_load_st", state_out, 1);
        s0 = strobe_cnt;
        for (int k = 2; k >= 0; k--) begin
            press_sub();
            check("man_step", count, k);
        end
        check("man_strobes", strobe_cnt - s0, 3);
        check("man_done_st", state_out, 3);
        press_sub();
        check("man_4th_cnt", count, 0);
        check("man_4th_strobes", strobe_cnt - s0, 3);

        // Bouncing sub button: toggles every 3 cycles, never accepted
        press_load(6'd3);
        s0 = strobe_cnt;
        for (int i = 0; i < 14; i++) begin
            btn_sub = (i % 2 == 0);
            cyc(3);
        end
        check("bnc_no_dec", count, 3);
        btn_sub = 1'b1;
        cyc(DB + 2);
        check("bnc_before", count, 3);
        cyc(1);
        check("bnc_after", count, 2);
        check("bnc_strobe", dec_strobe, 1);
        cyc(20);
        check("bnc_hold", count, 2);
        check("bnc_one", strobe_cnt - s0, 1);
        btn_sub = 1'b0;
        cyc(DB + 8);

        // Load zero goes straight to DONE
        press_load(6'd0);
        check("ld0_state", state_out, 3);
        check("ld0_count", count, 0);

        // Load and sub in the same cycle: load wins
        s0 = strobe_cnt;
        data_in  = 6'd40;
        btn_load = 1'b1;
        btn_sub  = 1'b1;
        cyc(DB + 8);
        btn_load = 1'b0;
        btn_sub  = 1'b0;
        cyc(DB + 8);
        check("ldsub_count", count, 40);
        check("ldsub_state", state_out, 1);
        check("ldsub_strobe", strobe_cnt - s0, 0);

        // Automatic countdown from 5
        press_load(6'd5);
        s0 = strobe_cnt;
        auto_en = 1'b1;
        cyc(2);
        check("auto_sync", state_out, 1);
        cyc(1);
        check("auto_run", state_out, 2);
        for (int k = 4; k >= 0; k--) begin
            cyc(TK - 1);
            check("auto_pre", count, k + 1);
            cyc(1);
            check("auto_dec", count, k);
            check("auto_strobe", dec_strobe, 1);
        end
        check("auto_done", state_out, 3);
        cyc(100);
        check("auto_hold_cnt", count, 0);
        check("auto_hold_st", state_out, 3);
        check("auto_strobes", strobe_cnt - s0, 5);

        // Mode switch at count 20
        auto_en = 1'b0;
        cyc(4);
        press_load(6'd22);
        auto_en = 1'b1;
        cyc(3);
        check("ms_run", state_out, 2);
        cyc(2 * TK);
        check("ms_at20", count, 20);
        auto_en = 1'b0;
        cyc(3);
        check("ms_ready", state_out, 1);
        check("ms_keep", count, 20);
        cyc(30);
        check("ms_no_tick", count, 20);
        press_sub();
        check("ms_sub", count, 19);

        // Reset mid-RUN at count 25
        press_load(6'd26);
        auto_en = 1'b1;
        cyc(3);
        check("mr_run", state_out, 2);
        cyc(TK);
        check("mr_at25", count, 25);
        #2 rst = 1'b0;
        #1;
        check("mr_count", count, 0);
        check("mr_state", state_out, 0);
        check("mr_zero", zero, 1);
        check("mr_strobe", dec_strobe, 0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
